mem_access_initiator: RTL and testbench

//  Load/store initiator for the Mini-MIPS datapath. Accepts one decoded memory op from

---
 rtl/mips_mem_pkg.sv | 27 ++
 rtl/mem_access_initiator_if.sv | 40 ++++
 rtl/mem_access_initiator_timeout_ctr.sv | 28 ++
 rtl/mem_access_initiator.sv | 140 ++++++++++++++
 tb/tb_mem_access_initiator.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the Mini-MIPS load/store initiator.
// Holds the FSM state encoding, exception codes and the address-fault rule.
package mips_mem_pkg;

    localparam int DEPTH_DEF   = 256;
    localparam int TIMEOUT_DEF = 15;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_REQ   = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [1:0] EXC_NONE     = 2'd0;
    localparam logic [1:0] EXC_MISALIGN = 2'd1;
    localparam logic [1:0] EXC_RANGE    = 2'd2;
    localparam logic [1:0] EXC_TIMEOUT  = 2'd3;

    // Misalignment outranks out-of-range so a bad low address never probes the range.
    function automatic logic [1:0] addr_fault(input logic [31:0] addr, input logic [31:0] depth);
        if (addr[1:0] != 2'b00) return EXC_MISALIGN;
        if ({2'b00, addr[31:2]} >= depth) return EXC_RANGE;
        return EXC_NONE;
    endfunction

endpackage

// File: rtl/mem_access_initiator_if.sv
// Op, memory and writeback bundle between execute, the initiator and data memory.
// master = the initiator; slave = execute/memory/writeback side.
interface mem_access_initiator_if #(parameter int IDX_W = 8);

    logic             op_valid;
    logic             op_ready;
    logic             op_store;
    logic             op_fp;
    logic [4:0]       op_reg;
    logic [31:0]      op_addr;
    logic [31:0]      op_wdata;

    logic             mem_req;
    logic             mem_we;
    logic [IDX_W-1:0] mem_idx;
    logic [31:0]      mem_wdata;
    logic             mem_ack;
    logic [31:0]      mem_rdata;

    logic             wb_valid;
    logic             wb_fp;
    logic [4:0]       wb_reg;
    logic [31:0]      wb_data;
    logic             done;
    logic             exc_valid;
    logic [1:0]       exc_code;

    modport master (
        input  op_valid, op_store, op_fp, op_reg, op_addr, op_wdata, mem_ack, mem_rdata,
        output op_ready, mem_req, mem_we, mem_idx, mem_wdata,
               wb_valid, wb_fp, wb_reg, wb_data, done, exc_valid, exc_code
    );

    modport slave (
        output op_valid, op_store, op_fp, op_reg, op_addr, op_wdata, mem_ack, mem_rdata,
        input  op_ready, mem_req, mem_we, mem_idx, mem_wdata,
               wb_valid, wb_fp, wb_reg, wb_data, done, exc_valid, exc_code
    );

endinterface

// File: rtl/mem_access_initiator_timeout_ctr.sv
// Request wait timer: cleared before a request, counts each waiting cycle,
// flags expiry on the cycle the count reaches TIMEOUT-1.
module mem_timeout_ctr #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)     cnt_d = 8'd0;
        else if (en_i) cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= 8'd0;
        else        cnt_q <= cnt_d;
    end

    assign expire_o = en_i && (cnt_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_initiator.sv
// Single-outstanding load/store initiator: latches one op, checks the address,
// runs the memory req/ack handshake and retires with writeback or an exception.
module mem_access_initiator
    import mips_mem_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEF,
    parameter int IDX_W   = $clog2(DEPTH),
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mem_access_initiator_if.master bus
);

    state_t           state_q;
    logic             store_q, fp_q;
    logic [4:0]       reg_q;
    logic [31:0]      addr_q;

    logic             op_ready_q, mem_req_q, mem_we_q;
    logic [IDX_W-1:0] mem_idx_q;
    logic [31:0]      mem_wdata_q;
    logic             wb_valid_q, wb_fp_q, done_q, exc_valid_q;
    logic [4:0]       wb_reg_q;
    logic [31:0]      wb_data_q;
    logic [1:0]       exc_code_q;

    logic [1:0]       chk_code;
    logic             expire;

    assign chk_code = addr_fault(addr_q, 32'(DEPTH));

    mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmr (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (state_q == S_CHECK),
        .en_i     (state_q == S_REQ),
        .expire_o (expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            store_q     <= 1'b0;
            fp_q        <= 1'b0;
            reg_q       <= 5'd0;
            addr_q      <= 32'd0;
            op_ready_q  <= 1'b1;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_idx_q   <= '0;
            mem_wdata_q <= 32'd0;
            wb_valid_q  <= 1'b0;
            wb_fp_q     <= 1'b0;
            wb_reg_q    <= 5'd0;
            wb_data_q   <= 32'd0;
            done_q      <= 1'b0;
            exc_valid_q <= 1'b0;
            exc_code_q  <= EXC_NONE;
        end else begin
            done_q      <= 1'b0;
            wb_valid_q  <= 1'b0;
            exc_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.op_valid && op_ready_q) begin
                        store_q     <= bus.op_store;
                        fp_q        <= bus.op_fp;
                        reg_q       <= bus.op_reg;
                        addr_q      <= bus.op_addr;
                        mem_we_q    <= bus.op_store;
                        mem_idx_q   <= bus.op_addr[IDX_W+1:2];
                        mem_wdata_q <= bus.op_wdata;
                        op_ready_q  <= 1'b0;
                        state_q     <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (chk_code != EXC_NONE) begin
                        done_q      <= 1'b1;
                        exc_valid_q <= 1'b1;
                        exc_code_q  <= chk_code;
                        wb_fp_q     <= fp_q;
                        wb_reg_q    <= reg_q;
                        state_q     <= S_RESP;
                    end else begin
                        mem_req_q   <= 1'b1;
                        state_q     <= S_REQ;
                    end
                end
                S_REQ: begin
                    // Ack is tested first so an ack on the expiry cycle still succeeds.
                    if (bus.mem_ack) begin
                        mem_req_q   <= 1'b0;
                        done_q      <= 1'b1;
                        exc_code_q  <= EXC_NONE;
                        wb_fp_q     <= fp_q;
                        wb_reg_q    <= reg_q;
                        if (!store_q) begin
                            wb_valid_q <= 1'b1;
                            wb_data_q  <= bus.mem_rdata;
                        end
                        state_q     <= S_RESP;
                    end else if (expire) begin
                        mem_req_q   <= 1'b0;
                        done_q      <= 1'b1;
                        exc_valid_q <= 1'b1;
                        exc_code_q  <= EXC_TIMEOUT;
                        wb_fp_q     <= fp_q;
                        wb_reg_q    <= reg_q;
                        state_q     <= S_RESP;
                    end
                end
                S_RESP: begin
                    op_ready_q <= 1'b1;
                    state_q    <= S_IDLE;
                end
                default: begin
                    op_ready_q <= 1'b1;
                    mem_req_q  <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.op_ready  = op_ready_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_idx   = mem_idx_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.wb_valid  = wb_valid_q;
    assign bus.wb_fp     = wb_fp_q;
    assign bus.wb_reg    = wb_reg_q;
    assign bus.wb_data   = wb_data_q;
    assign bus.done      = done_q;
    assign bus.exc_valid = exc_valid_q;
    assign bus.exc_code  = exc_code_q;

endmodule

// File: tb/tb_mem_access_initiator.sv
// Directed and random load/store ops against a word-array memory and a reference
// model that predicts fault code, latency, request length and writeback data.
module tb_mem_access_initiator;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];

    mem_access_initiator_if #(.IDX_W(8)) bus();

    mem_access_initiator #(.DEPTH(256), .IDX_W(8), .TIMEOUT(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called one tick after a rising edge with the DUT idle; returns in the same phase, idle again.
    task automatic run_op(input logic st, input logic fp, input logic [4:0] rg,
                          input logic [31:0] addr, input logic [31:0] wd, input int dly);
        int          cyc, nreq, exp_lat, exp_req;
        logic        got;
        logic [1:0]  ecode;
        logic [31:0] exp_data;
        if (addr % 4 != 0)        ecode = 2'd1;
        else if (addr / 4 >= 256) ecode = 2'd2;
        else if (dly >= 15)       ecode = 2'd3;
        else                      ecode = 2'd0;
        exp_req  = (ecode == 2'd1 || ecode == 2'd2) ? 0 : (ecode == 2'd3) ? 15 : dly + 1;
        exp_lat  = 2 + exp_req;
        exp_data = ref_mem[addr[9:2]];

        chk("op_ready_idle", bus.op_ready, 1);
        bus.op_valid = 1'b1; bus.op_store = st; bus.op_fp = fp; bus.op_reg = rg;
        bus.op_addr = addr; bus.op_wdata = wd;
        step();
        bus.op_valid = 1'b0;
        bus.op_store = 1'($urandom); bus.op_fp = 1'($urandom); bus.op_reg = 5'($urandom);
        bus.op_addr = $urandom; bus.op_wdata = $urandom;

        cyc = 1; nreq = 0; got = 1'b0;
        while (!got && cyc < 40) begin
            if (bus.done) got = 1'b1;
            else begin
                chk("op_ready_busy", bus.op_ready, 0);
                if (bus.mem_req) begin
                    chk("mem_we", bus.mem_we, st);
                    chk("mem_idx", bus.mem_idx, addr[9:2]);
                    if (st) chk("mem_wdata", bus.mem_wdata, wd);
                    if (nreq == dly) begin
                        bus.mem_ack = 1'b1;
                        if (st) begin
                            mem[bus.mem_idx] = bus.mem_wdata;
                            bus.mem_rdata = $urandom;
                        end else bus.mem_rdata = mem[bus.mem_idx];
                    end
                    nreq++;
                end
                step();
                bus.mem_ack = 1'b0;
                cyc++;
            end
        end
        chk("done_seen", got, 1);
        chk("latency", cyc, exp_lat);
        chk("req_cycles", nreq, exp_req);
        chk("mem_req_resp", bus.mem_req, 0);
        chk("exc_valid", bus.exc_valid, ecode != 2'd0);
        if (ecode != 2'd0) chk("exc_code", bus.exc_code, ecode);
        chk("wb_valid", bus.wb_valid, ecode == 2'd0 && !st);
        if (ecode == 2'd0 && !st) begin
            chk("wb_fp", bus.wb_fp, fp);
            chk("wb_reg", bus.wb_reg, rg);
            chk("wb_data", bus.wb_data, exp_data);
        end
        if (ecode == 2'd0 && st) ref_mem[addr[9:2]] = wd;
        step();
        chk("done_pulse", bus.done, 0);
        chk("op_ready_back", bus.op_ready, 1);
    endtask

    initial begin
        logic [31:0] a, w;
        int          d, r;
        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;
        bus.op_valid = 0; bus.op_store = 0; bus.op_fp = 0; bus.op_reg = 0;
        bus.op_addr = 0; bus.op_wdata = 0; bus.mem_ack = 0; bus.mem_rdata = 0;

        #12;
        chk("rst_op_ready", bus.op_ready, 1);
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_wb_valid", bus.wb_valid, 0);
        chk("rst_exc_valid", bus.exc_valid, 0);
        chk("rst_exc_code", bus.exc_code, 0);
        chk("rst_wb_data", bus.wb_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // LW GPR with immediate ack, SWC1 to the last word, the three address faults
        run_op(1'b0, 1'b0, 5'd9,  32'h10,  32'h0,        0);
        run_op(1'b1, 1'b1, 5'd2,  32'h3FC, 32'h3F800000, 3);
        run_op(1'b0, 1'b1, 5'd4,  32'h3FC, 32'h0,        1);
        run_op(1'b0, 1'b0, 5'd1,  32'h12,  32'h0,        0);
        run_op(1'b1, 1'b0, 5'd1,  32'h400, 32'h1234,     0);
        run_op(1'b0, 1'b0, 5'd1,  32'h402, 32'h0,        0);
        // No ack at all, then ack on the last allowed cycle
        run_op(1'b0, 1'b0, 5'd7,  32'h80,  32'h0,        99);
        run_op(1'b0, 1'b0, 5'd7,  32'h80,  32'h0,        14);

        // op_valid held across two ops: the second is only taken once back in IDLE
        bus.op_valid = 1; bus.op_store = 0; bus.op_fp = 0; bus.op_reg = 5'd3; bus.op_addr = 32'h12;
        step();
        chk("b2b_ready_check", bus.op_ready, 0);
        bus.op_reg = 5'd7; bus.op_addr = 32'h400;
        step();
        chk("b2b_done1", bus.done, 1);
        chk("b2b_code1", bus.exc_code, 1);
        chk("b2b_ready_resp", bus.op_ready, 0);
        step();
        chk("b2b_ready_idle", bus.op_ready, 1);
        chk("b2b_idle_done", bus.done, 0);
        step();
        chk("b2b_ready_check2", bus.op_ready, 0);
        bus.op_valid = 0;
        step();
        chk("b2b_done2", bus.done, 1);
        chk("b2b_code2", bus.exc_code, 2);
        step();
        chk("b2b_ready_end", bus.op_ready, 1);

        // Reset while a request is outstanding; a late ack must be ignored
        bus.op_valid = 1; bus.op_store = 0; bus.op_addr = 32'h40; bus.op_reg = 5'd5;
        step();
        bus.op_valid = 0;
        step();
        chk("rr_req_on", bus.mem_req, 1);
        step();
        chk("rr_req_hold", bus.mem_req, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rr_req_drop", bus.mem_req, 0);
        chk("rr_ready", bus.op_ready, 1);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hBAD0BAD0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("rr_late_done", bus.done, 0);
        chk("rr_late_wb", bus.wb_valid, 0);
        chk("rr_late_req", bus.mem_req, 0);
        chk("rr_late_ready", bus.op_ready, 1);
        bus.mem_ack = 1'b0;
        step();

        for (int n = 0; n < 60; n++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0)      a = ({24'd0, 8'($urandom)} << 2) | 32'($urandom_range(1, 3));
            else if (r == 1) a = {$urandom} & 32'hFFFF_FFFC | 32'h0000_0400;
            else             a = {24'd0, 8'($urandom)} << 2;
            r = int'($urandom_range(0, 9));
            if (r < 7)       d = r % 4;
            else if (r == 7) d = 14;
            else             d = 15 + r;
            w = $urandom;
            run_op(1'($urandom), 1'($urandom), 5'($urandom), a, w, d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
